cv32e40x_hazard_scoreboard: RTL and testbench
=============================================

// Module: cv32e40x_hazard_scoreboard
// PURPOSE
//  Parametrised hazard scoreboard between ID and the execute/writeback pipeline.
//  Generalises the load-use / JALR stall logic to N read ports and multiple outstanding long-latency writes.
//  Long-latency writes are loads or multicycle ops; each gets a per-register pending counter.
//  Drives the ID issue handshake, per-port WB forwarding selects and a saturating stall-cycle counter.
// PARAMETERS
//  NUM_READ_PORTS   2   register read ports checked per issued instruction
//  NUM_REGS         32  architectural registers; x0 is never tracked
//  MAX_PENDING      2   max outstanding long writes per register and in total (>=1)
//  STALL_CNT_W      16  width of stall_cycles_o
// PORTS
//  clk              in   1                       clock
//  rst              in   1                       reset, synchronous, active-high
//  issue_valid_i    in   1                       ID presents an instruction
//  issue_ready_o    out  1                       scoreboard accepts it (issue fires = valid & ready)
//  issue_re_i       in   NUM_READ_PORTS          per-port read enable
//  issue_raddr_i    in   NUM_READ_PORTS x clog2(NUM_REGS)  read addresses
//  issue_we_i       in   1                       instruction writes rd
//  issue_long_i     in   1                       rd write is long-latency (tracked)
//  issue_waddr_i    in   clog2(NUM_REGS)         rd
//  retire_valid_i   in   1                       a long write completes in WB this cycle
//  retire_waddr_i   in   clog2(NUM_REGS)         register being written back
//  flush_i          in   1                       pipeline kill; discard all pending writes
//  fw_wb_sel_o      out  NUM_READ_PORTS          1 = port takes WB retire data, 0 = regfile
//  hazard_o         out  1                       RAW/WAW/capacity stall active this cycle
//  pending_any_o    out  1                       total outstanding count != 0
//  err_o            out  1                       sticky: retire to a register with count 0
//  stall_cycles_o   out  STALL_CNT_W             saturating count of cycles with hazard_o & issue_valid_i
// BEHAVIOUR
//  Reset: all counters, total count, err_o and stall_cycles_o are 0.
//  Reset outputs: issue_ready_o=1, hazard_o=0, fw_wb_sel_o=0, pending_any_o=0.
//  State: cnt[r] per register r (1..NUM_REGS-1), width clog2(MAX_PENDING+1); total count of same width.
//  RAW per port p, when issue_re_i[p] and raddr!=0 and cnt[raddr]!=0:
//   - forwarded, no stall, if retire_valid_i & retire_waddr_i==raddr & cnt==1;
//     fw_wb_sel_o[p]=1 in this case only;
//   - otherwise the port stalls (cnt>1 means a younger write is still pending).
//  WAW: issue_we_i & issue_long_i & waddr!=0 & cnt[waddr]==MAX_PENDING, with no same-register retire -> stall.
//  Capacity: issue_long_i & total==MAX_PENDING & !retire_valid_i -> stall.
//  hazard_o = issue_valid_i & (any RAW stall | WAW | capacity). issue_ready_o = !hazard_o & !flush_i.
//  All hazard, ready and fw outputs are combinational from inputs and state: 0-cycle latency.
//  Counter update on the clk edge:
//   - issue fires with we & long & waddr!=0 -> +1;
//   - retire_valid_i with cnt!=0 -> -1;
//   - issue and retire to the same register in one cycle -> net unchanged; total follows the same rule.
//  Retire to x0, or to a register with cnt==0: no counter change, err_o set (sticky until rst).
//  Exception: x0 retire sets no error.
//  Short writes (issue_long_i=0) are not tracked; EX forwarding for them is handled elsewhere.
//  flush_i: issue_ready_o=0 that cycle; next cycle all cnt and total are 0.
//   Flush wins over simultaneous issue or retire; err_o and stall_cycles_o are kept.
//  stall_cycles_o increments once per cycle with hazard_o=1 and saturates at all-ones.
//  rst mid-operation (any cnt!=0) returns all state to reset values on the next edge.
// TESTING
//  1 Load-use: issue long waddr=5; next cycle read raddr[0]=5, no retire -> hazard_o=1, ready=0; retire 5 next -> hazard_o=0, fw_wb_sel_o[0]=1.
//  2 Two long writes to x7 (MAX_PENDING=2), read x7 while first retires -> hazard_o=1, cnt[7]=1 after; second retire + read -> forward, no stall.
//  3 Capacity: 2 long writes to x3,x4 outstanding, issue long to x9, no retire -> hazard_o=1; same with retire of x3 -> accepted, total stays 2.
//  4 Same-cycle issue long x6 and retire x6 with cnt[6]=1 -> cnt[6] stays 1, pending_any_o=1.
//  5 flush_i with cnt[5]=2 and issue_valid_i=1 -> issue_ready_o=0; next cycle pending_any_o=0, read x5 -> no hazard.
//  6 Retire x10 with cnt=0 -> err_o=1, held after further traffic; 2^16+5 hazard cycles -> stall_cycles_o=16'hFFFF.

Source files
------------

// File: rtl/cv32e40x_hazard_scoreboard.sv
// Hazard scoreboard between ID and the long-latency write pipeline: tracks outstanding
// long writes per register, stalls RAW/WAW/capacity hazards and selects WB forwarding.
module cv32e40x_hazard_scoreboard #(
    parameter int unsigned NUM_READ_PORTS = 2,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned MAX_PENDING    = 2,
    parameter int unsigned STALL_CNT_W    = 16,
    localparam int unsigned AW            = $clog2(NUM_REGS),
    localparam int unsigned CW            = $clog2(MAX_PENDING + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                issue_valid_i,
    output logic                                issue_ready_o,
    input  logic [NUM_READ_PORTS-1:0]           issue_re_i,
    input  logic [NUM_READ_PORTS-1:0][AW-1:0]   issue_raddr_i,
    input  logic                                issue_we_i,
    input  logic                                issue_long_i,
    input  logic [AW-1:0]                       issue_waddr_i,
    input  logic                                retire_valid_i,
    input  logic [AW-1:0]                       retire_waddr_i,
    input  logic                                flush_i,
    output logic [NUM_READ_PORTS-1:0]           fw_wb_sel_o,
    output logic                                hazard_o,
    output logic                                pending_any_o,
    output logic                                err_o,
    output logic [STALL_CNT_W-1:0]              stall_cycles_o
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);

    logic [CW-1:0]          cnt_q [NUM_REGS];
    logic [CW-1:0]          cnt_d [NUM_REGS];
    logic [CW-1:0]          total_q;
    logic [CW-1:0]          total_d;
    logic                   err_q;
    logic [STALL_CNT_W-1:0] stall_q;

    logic raw_stall;
    logic waw_stall;
    logic cap_stall;
    logic issue_fire;
    logic inc_fire;
    logic dec_fire;
    logic retire_err;

    // A pending read is only satisfied by WB when the retiring write is the last one in flight.
    always_comb begin
        raw_stall   = 1'b0;
        fw_wb_sel_o = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (issue_re_i[p] && (issue_raddr_i[p] != '0) && (cnt_q[issue_raddr_i[p]] != '0)) begin
                if (retire_valid_i && (retire_waddr_i == issue_raddr_i[p]) &&
                    (cnt_q[issue_raddr_i[p]] == CNT_ONE)) begin
                    fw_wb_sel_o[p] = 1'b1;
                end else begin
                    raw_stall = 1'b1;
                end
            end
        end
    end

    always_comb begin
        waw_stall = issue_we_i && issue_long_i && (issue_waddr_i != '0) &&
                    (cnt_q[issue_waddr_i] == CNT_MAX) &&
                    !(retire_valid_i && (retire_waddr_i == issue_waddr_i));
        cap_stall = issue_long_i && (total_q == CNT_MAX) && !retire_valid_i;

        hazard_o      = issue_valid_i && (raw_stall || waw_stall || cap_stall);
        issue_ready_o = !hazard_o && !flush_i;
        issue_fire    = issue_valid_i && issue_ready_o;

        inc_fire   = issue_fire && issue_we_i && issue_long_i && (issue_waddr_i != '0);
        dec_fire   = retire_valid_i && (retire_waddr_i != '0) && (cnt_q[retire_waddr_i] != '0);
        retire_err = retire_valid_i && (retire_waddr_i != '0) && (cnt_q[retire_waddr_i] == '0);
    end

    // Issue and retire hitting the same register cancel out; x0 is never touched.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                if (inc_fire && (issue_waddr_i == AW'(r)) &&
                    !(dec_fire && (retire_waddr_i == AW'(r)))) begin
                    cnt_d[r] = cnt_q[r] + CNT_ONE;
                end else if (dec_fire && (retire_waddr_i == AW'(r)) &&
                             !(inc_fire && (issue_waddr_i == AW'(r)))) begin
                    cnt_d[r] = cnt_q[r] - CNT_ONE;
                end
            end
        end

        total_d = total_q;
        if (inc_fire && !dec_fire) begin
            total_d = total_q + CNT_ONE;
        end else if (dec_fire && !inc_fire) begin
            total_d = total_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            total_q <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            if (flush_i) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    cnt_q[r] <= '0;
                end
                total_q <= '0;
            end else begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    cnt_q[r] <= cnt_d[r];
                end
                total_q <= total_d;
            end

            if (retire_err) begin
                err_q <= 1'b1;
            end

            // Saturate rather than wrap so long stalls stay visible.
            if (hazard_o && !(&stall_q)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign pending_any_o  = (total_q != '0);
    assign err_o          = err_q;
    assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_cv32e40x_hazard_scoreboard.sv
// Directed and randomized bench for the hazard scoreboard, checked against a queue-based
// model of outstanding long writes.
module tb_cv32e40x_hazard_scoreboard;

    localparam int NRP  = 2;
    localparam int NREG = 32;
    localparam int MAXP = 2;
    localparam int SW   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic             issue_ready;
    logic [1:0]       issue_re;
    logic [1:0][4:0]  issue_raddr;
    logic             issue_we;
    logic             issue_long;
    logic [4:0]       issue_waddr;
    logic             retire_valid;
    logic [4:0]       retire_waddr;
    logic             flush;
    logic [1:0]       fw_wb_sel;
    logic             hazard;
    logic             pending_any;
    logic             err;
    logic [SW-1:0]    stall_cycles;

    always #5 clk = ~clk;

    cv32e40x_hazard_scoreboard #(
        .NUM_READ_PORTS(NRP),
        .NUM_REGS      (NREG),
        .MAX_PENDING   (MAXP),
        .STALL_CNT_W   (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .issue_re_i    (issue_re),
        .issue_raddr_i (issue_raddr),
        .issue_we_i    (issue_we),
        .issue_long_i  (issue_long),
        .issue_waddr_i (issue_waddr),
        .retire_valid_i(retire_valid),
        .retire_waddr_i(retire_waddr),
        .flush_i       (flush),
        .fw_wb_sel_o   (fw_wb_sel),
        .hazard_o      (hazard),
        .pending_any_o (pending_any),
        .err_o         (err),
        .stall_cycles_o(stall_cycles)
    );

    int checks = 0;
    int errors = 0;

    // Model: ordered list of outstanding long-write destinations.
    int pend_q[$];
    bit mdl_err   = 1'b0;
    int mdl_stall = 0;
    bit exp_hazard;
    bit exp_ready;
    bit [1:0] exp_fw;

    function automatic int countOf(int r);
        int n = 0;
        foreach (pend_q[i]) if (pend_q[i] == r) n++;
        return n;
    endfunction

    task automatic modelEval();
        bit raw;
        bit waw;
        bit cap;
        int a;
        raw    = 1'b0;
        exp_fw = '0;
        for (int p = 0; p < NRP; p++) begin
            a = int'(issue_raddr[p]);
            if (issue_re[p] && a != 0 && countOf(a) > 0) begin
                if (retire_valid && int'(retire_waddr) == a && countOf(a) == 1) exp_fw[p] = 1'b1;
                else raw = 1'b1;
            end
        end
        waw = issue_we && issue_long && issue_waddr != 0 && countOf(int'(issue_waddr)) >= MAXP &&
              !(retire_valid && retire_waddr == issue_waddr);
        cap = issue_long && pend_q.size() >= MAXP && !retire_valid;
        exp_hazard = issue_valid && (raw || waw || cap);
        exp_ready  = !exp_hazard && !flush;
    endtask

    task automatic modelCommit();
        if (rst) begin
            pend_q.delete();
            mdl_err   = 1'b0;
            mdl_stall = 0;
        end else begin
            if (retire_valid && retire_waddr != 0 && countOf(int'(retire_waddr)) == 0) mdl_err = 1'b1;
            if (exp_hazard && mdl_stall < 65535) mdl_stall++;
            if (flush) begin
                pend_q.delete();
            end else begin
                if (retire_valid && retire_waddr != 0) begin
                    for (int i = 0; i < pend_q.size(); i++) begin
                        if (pend_q[i] == int'(retire_waddr)) begin
                            pend_q.delete(i);
                            break;
                        end
                    end
                end
                if (issue_valid && exp_ready && issue_we && issue_long && issue_waddr != 0)
                    pend_q.push_back(int'(issue_waddr));
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit [1:0] re, input bit [4:0] ra0, input bit [4:0] ra1,
                                 input bit we, input bit lng, input bit [4:0] wa,
                                 input bit rv, input bit [4:0] rw, input bit fl, input bit rs);
        issue_valid    = v;
        issue_re       = re;
        issue_raddr[0] = ra0;
        issue_raddr[1] = ra1;
        issue_we       = we;
        issue_long     = lng;
        issue_waddr    = wa;
        retire_valid   = rv;
        retire_waddr   = rw;
        flush          = fl;
        rst            = rs;
    endtask

    task automatic settle(input string tag);
        #1;
        modelEval();
        checkOutput({tag, "_ready"},   32'(issue_ready),  32'(exp_ready));
        checkOutput({tag, "_hazard"},  32'(hazard),       32'(exp_hazard));
        checkOutput({tag, "_fw"},      32'(fw_wb_sel),    32'(exp_fw));
        checkOutput({tag, "_pending"}, 32'(pending_any),  32'(pend_q.size() != 0));
        checkOutput({tag, "_err"},     32'(err),          32'(mdl_err));
        checkOutput({tag, "_stall"},   32'(stall_cycles), 32'(mdl_stall));
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelCommit();
        #1;
    endtask

    task automatic issueLong(input bit [4:0] wa, input string tag);
        applyStimulus(1, 2'b00, 0, 0, 1, 1, wa, 0, 0, 0, 0);
        settle(tag);
        clockEdge();
    endtask

    task automatic retireOnly(input bit [4:0] rw, input string tag);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 1, rw, 0, 0);
        settle(tag);
        clockEdge();
    endtask

    initial begin
        bit v, we, lng, rv, fl, rs;
        bit [1:0] re;
        bit [4:0] ra0, ra1, wa, rw;

        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;

        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle("reset");
        checkOutput("reset_ready_one", 32'(issue_ready), 32'd1);
        checkOutput("reset_stall_zero", 32'(stall_cycles), 32'd0);
        clockEdge();

        // Load-use
        issueLong(5'd5, "t1_issue");
        applyStimulus(1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        settle("t1_use");
        checkOutput("t1_use_hazard", 32'(hazard), 32'd1);
        checkOutput("t1_use_ready", 32'(issue_ready), 32'd0);
        clockEdge();
        applyStimulus(1, 2'b01, 5, 0, 0, 0, 0, 1, 5, 0, 0);
        settle("t1_fwd");
        checkOutput("t1_fwd_hazard", 32'(hazard), 32'd0);
        checkOutput("t1_fwd_sel", 32'(fw_wb_sel), 32'd1);
        clockEdge();

        // Two outstanding writes to x7
        issueLong(5'd7, "t2_issue_a");
        issueLong(5'd7, "t2_issue_b");
        applyStimulus(1, 2'b10, 0, 7, 0, 0, 0, 1, 7, 0, 0);
        settle("t2_first");
        checkOutput("t2_first_hazard", 32'(hazard), 32'd1);
        clockEdge();
        applyStimulus(1, 2'b10, 0, 7, 0, 0, 0, 1, 7, 0, 0);
        settle("t2_second");
        checkOutput("t2_second_hazard", 32'(hazard), 32'd0);
        checkOutput("t2_second_sel", 32'(fw_wb_sel), 32'd2);
        clockEdge();
        checkOutput("t2_drained", 32'(pending_any), 32'd0);

        // Capacity
        issueLong(5'd3, "t3_issue_3");
        issueLong(5'd4, "t3_issue_4");
        applyStimulus(1, 2'b00, 0, 0, 1, 1, 9, 0, 0, 0, 0);
        settle("t3_full");
        checkOutput("t3_full_hazard", 32'(hazard), 32'd1);
        clockEdge();
        applyStimulus(1, 2'b00, 0, 0, 1, 1, 9, 1, 3, 0, 0);
        settle("t3_swap");
        checkOutput("t3_swap_ready", 32'(issue_ready), 32'd1);
        clockEdge();
        applyStimulus(1, 2'b00, 0, 0, 1, 1, 10, 0, 0, 0, 0);
        settle("t3_still_full");
        checkOutput("t3_still_full_hazard", 32'(hazard), 32'd1);
        clockEdge();
        retireOnly(5'd4, "t3_ret4");
        retireOnly(5'd9, "t3_ret9");

        // Same-cycle issue and retire on x6
        issueLong(5'd6, "t4_issue");
        applyStimulus(1, 2'b00, 0, 0, 1, 1, 6, 1, 6, 0, 0);
        settle("t4_both");
        clockEdge();
        checkOutput("t4_pending", 32'(pending_any), 32'd1);
        retireOnly(5'd6, "t4_ret");
        applyStimulus(1, 2'b01, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        settle("t4_read");
        checkOutput("t4_read_hazard", 32'(hazard), 32'd0);
        clockEdge();

        // Flush
        issueLong(5'd5, "t5_issue_a");
        issueLong(5'd5, "t5_issue_b");
        applyStimulus(1, 2'b00, 0, 0, 1, 1, 8, 0, 0, 1, 0);
        settle("t5_flush");
        checkOutput("t5_flush_ready", 32'(issue_ready), 32'd0);
        clockEdge();
        checkOutput("t5_pending", 32'(pending_any), 32'd0);
        applyStimulus(1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        settle("t5_read");
        checkOutput("t5_read_hazard", 32'(hazard), 32'd0);
        clockEdge();

        // Randomized traffic; retires only target registers actually outstanding
        for (int n = 0; n < 600; n++) begin
            v   = 1'($urandom_range(0, 1));
            re  = 2'($urandom_range(0, 3));
            ra0 = 5'($urandom_range(0, 7));
            ra1 = 5'($urandom_range(0, 7));
            we  = 1'($urandom_range(0, 3) != 0);
            lng = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 7));
            rv  = 1'b0;
            rw  = 5'd0;
            if (pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                rv = 1'b1;
                rw = 5'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
            end
            fl = 1'($urandom_range(0, 15) == 0);
            if (fl) rv = 1'b0;
            rs = 1'($urandom_range(0, 63) == 0);
            applyStimulus(v, re, ra0, ra1, we, lng, wa, rv, rw, fl, rs);
            settle("rand");
            clockEdge();
        end

        // Sticky error and stall saturation
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        settle("t6_rst");
        clockEdge();
        retireOnly(5'd0, "t6_ret_x0");
        checkOutput("t6_x0_no_err", 32'(err), 32'd0);
        retireOnly(5'd10, "t6_ret_x10");
        checkOutput("t6_err_set", 32'(err), 32'd1);
        issueLong(5'd5, "t6_issue");
        retireOnly(5'd5, "t6_ret5");
        checkOutput("t6_err_held", 32'(err), 32'd1);
        issueLong(5'd5, "t6_issue_hold");
        for (int n = 0; n < 65541; n++) begin
            applyStimulus(1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 0);
            settle("t6_sat");
            clockEdge();
        end
        checkOutput("t6_stall_saturated", 32'(stall_cycles), 32'h0000FFFF);
        checkOutput("t6_err_final", 32'(err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
